// File: rtl/regfile_writeback.sv
// Write-side driver for the 32x32 register file: merges ALU results and FIFO-buffered
// load results onto the single write port and reports pending destinations.
module regfile_writeback #(
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     alu_valid,
  output logic                     alu_ready,
  input  logic [4:0]               alu_rd,
  input  logic [31:0]              alu_data,
  input  logic                     mem_valid,
  input  logic [4:0]               mem_rd,
  input  logic [31:0]              mem_data,
  output logic [4:0]               rd_addr,
  output logic [31:0]              data_in,
  output logic                     write_enable,
  output logic [31:0]              busy_mask,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     mem_overflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned SW = $clog2(STARVE_LIMIT + 2);
  localparam logic [SW-1:0] SLIM = SW'(STARVE_LIMIT);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [4:0]    fifo_rd_q   [DEPTH];
  logic [31:0]   fifo_data_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic [SW-1:0] starve_q, starve_d;
  logic [4:0]    rd_q, rd_d;
  logic [31:0]   data_q, data_d;
  logic          we_q, we_d;
  logic          ovf_q, ovf_d;

  logic          fifo_ne, fifo_full, fifo_prio, alu_take, pop, push, sel;
  logic [4:0]    sel_rd;
  logic [31:0]   sel_data;

  always_comb begin
    fifo_ne   = (count_q != '0);
    fifo_full = (count_q == FULL);
    fifo_prio = fifo_ne && (starve_q < SLIM);
    alu_ready = !fifo_prio;
    alu_take  = alu_valid && !fifo_prio;
    pop       = fifo_prio || (!alu_valid && fifo_ne);
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    push      = mem_valid && (!fifo_full || pop);
    ovf_d     = ovf_q || (mem_valid && fifo_full && !pop);

    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    starve_d = '0;
    if (alu_valid && fifo_prio)
      starve_d = (starve_q == SLIM) ? starve_q : starve_q + SW'(1);

    sel      = pop || alu_take;
    sel_rd   = pop ? fifo_rd_q[rd_ptr_q]   : alu_rd;
    sel_data = pop ? fifo_data_q[rd_ptr_q] : alu_data;
    we_d     = sel && (sel_rd != '0);
    rd_d     = we_d ? sel_rd   : rd_q;
    data_d   = we_d ? sel_data : data_q;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd_q[wr_ptr_q]   <= mem_rd;
      fifo_data_q[wr_ptr_q] <= mem_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      starve_q <= '0;
      rd_q     <= '0;
      data_q   <= '0;
      we_q     <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q  <= count_d;
      starve_q <= starve_d;
      rd_q     <= rd_d;
      data_q   <= data_d;
      we_q     <= we_d;
      ovf_q    <= ovf_d;
    end
  end

  always_comb begin
    busy_mask = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (CW'(i) < count_q)
        busy_mask[fifo_rd_q[rd_ptr_q + AW'(i)]] = 1'b1;
    end
    if (we_q) busy_mask[rd_q] = 1'b1;
    busy_mask[0] = 1'b0;
  end

  assign rd_addr      = rd_q;
  assign data_in      = data_q;
  assign write_enable = we_q;
  assign fifo_count   = count_q;
  assign mem_overflow = ovf_q;

endmodule
